// File: rtl/cuda_alu_pkg.sv
// Shared opcode encodings and the stage-1 beat type for the pipelined ALU.
// The beat is sized for the widest supported operand; narrower instances use the low bits.
package cuda_alu_pkg;

    localparam int unsigned MAX_W   = 32;
    localparam int unsigned MAX_SHW = 6;

    localparam logic [2:0] OP_NOP_ERR = 3'b000;
    localparam logic [2:0] OP_ANDADD  = 3'b001;
    localparam logic [2:0] OP_SHL     = 3'b010;
    localparam logic [2:0] OP_SHR     = 3'b011;
    localparam logic [2:0] OP_ACC     = 3'b100;
    localparam logic [2:0] OP_ACLR    = 3'b101;

    typedef struct packed {
        logic [MAX_W-1:0]   a;
        logic [MAX_W-1:0]   b;
        logic [MAX_W-1:0]   c;
        logic [2:0]         op;
        logic [MAX_SHW-1:0] sh;
    } beat_t;

endpackage

// File: rtl/cuda_alu_pipe_if.sv
// Operand/result handshake bundle for cuda_alu_pipe.
// The master drives operands and out_ready; the slave is the ALU.
interface cuda_alu_pipe_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [2:0]       op;
    logic [SHW-1:0]   sh;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;
    logic             cay;
    logic             err;
    logic             err_sticky;
    logic [WIDTH:0]   acc;

    modport master (
        output in_valid, a, b, c, op, sh, out_ready,
        input  in_ready, out_valid, out, cay, err, err_sticky, acc
    );

    modport slave (
        input  in_valid, a, b, c, op, sh, out_ready,
        output in_ready, out_valid, out, cay, err, err_sticky, acc
    );
endinterface

// File: rtl/cuda_alu_core.sv
// Combinational ALU datapath for stage 2: result, carry, error and accumulator update.
// WIDTH must be below MAX_W so the unused high beat bits exist.
module cuda_alu_core
    import cuda_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = $clog2(WIDTH + 1)
) (
    input  beat_t          i_beat,
    input  logic [WIDTH:0] i_acc,
    output logic [WIDTH:0] o_out,
    output logic           o_cay,
    output logic           o_err,
    output logic [WIDTH:0] o_acc_next,
    output logic           o_acc_we,
    output logic           o_sticky_clr
);
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_andadd;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH+1:0] w_accsum;
    logic             w_unused_hi;

    assign w_a  = i_beat.a[WIDTH-1:0];
    assign w_b  = i_beat.b[WIDTH-1:0];
    assign w_c  = i_beat.c[WIDTH-1:0];
    assign w_sh = i_beat.sh[SHW-1:0];
    assign w_unused_hi = ^{i_beat.a[MAX_W-1:WIDTH], i_beat.b[MAX_W-1:WIDTH],
                           i_beat.c[MAX_W-1:WIDTH], i_beat.sh[MAX_SHW-1:SHW]};

    assign w_andadd = {1'b0, w_a & w_b} + {1'b0, w_c};
    // Shifts past the field width fall off naturally, giving 0 with no extra compare.
    assign w_shl    = {1'b0, w_a} << w_sh;
    // The appended zero catches a[sh-1] in bit 0; sh=0 reads that zero.
    assign w_shr    = {w_a, 1'b0} >> w_sh;
    assign w_accsum = {1'b0, i_acc} + {2'b00, w_a};

    always_comb begin
        o_out        = '0;
        o_cay        = 1'b0;
        o_err        = 1'b0;
        o_acc_next   = i_acc;
        o_acc_we     = 1'b0;
        o_sticky_clr = 1'b0;
        case (i_beat.op)
            OP_ANDADD: begin
                o_out = w_andadd;
                o_cay = w_andadd[WIDTH];
            end
            OP_SHL: begin
                o_out = w_shl;
                o_cay = w_shl[WIDTH];
            end
            OP_SHR: begin
                o_out = {1'b0, w_shr[WIDTH:1]};
                o_cay = w_shr[0];
            end
            OP_ACC: begin
                o_out      = w_accsum[WIDTH:0];
                o_cay      = w_accsum[WIDTH+1];
                o_acc_next = w_accsum[WIDTH:0];
                o_acc_we   = 1'b1;
            end
            OP_ACLR: begin
                o_acc_next   = '0;
                o_acc_we     = 1'b1;
                o_sticky_clr = 1'b1;
            end
            default: o_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/cuda_alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds the accepted beat, S2 holds the result,
// the accumulator and the sticky error flag.
module cuda_alu_pipe
    import cuda_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            rst,
    cuda_alu_pipe_if.slave bus
);
    beat_t          w_beat;
    beat_t          r_s1_beat;
    logic           r_s1_valid;
    logic           r_s2_valid;
    logic [WIDTH:0] r_out;
    logic           r_cay;
    logic           r_err;
    logic           r_err_sticky;
    logic [WIDTH:0] r_acc;
    logic           w_s1_load;
    logic           w_s2_load;
    logic           w_in_ready;
    logic [WIDTH:0] w_core_out;
    logic           w_core_cay;
    logic           w_core_err;
    logic [WIDTH:0] w_acc_next;
    logic           w_acc_we;
    logic           w_sticky_clr;

    assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_s1_load  = bus.in_valid && w_in_ready;

    always_comb begin
        w_beat                = '0;
        w_beat.a[WIDTH-1:0]   = bus.a;
        w_beat.b[WIDTH-1:0]   = bus.b;
        w_beat.c[WIDTH-1:0]   = bus.c;
        w_beat.op             = bus.op;
        w_beat.sh[SHW-1:0]    = bus.sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_beat  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_beat  <= w_beat;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    cuda_alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .i_beat       (r_s1_beat),
        .i_acc        (r_acc),
        .o_out        (w_core_out),
        .o_cay        (w_core_cay),
        .o_err        (w_core_err),
        .o_acc_next   (w_acc_next),
        .o_acc_we     (w_acc_we),
        .o_sticky_clr (w_sticky_clr)
    );

    // acc and err_sticky move only on an S2 load, so a stalled beat is applied once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_out        <= '0;
            r_cay        <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_acc        <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_out      <= w_core_out;
            r_cay      <= w_core_cay;
            r_err      <= w_core_err;
            if (w_acc_we) begin
                r_acc <= w_acc_next;
            end
            if (w_sticky_clr) begin
                r_err_sticky <= 1'b0;
            end else if (w_core_err) begin
                r_err_sticky <= 1'b1;
            end
        end else if (bus.out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out        = r_out;
    assign bus.cay        = r_cay;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.acc        = r_acc;
endmodule

// File: tb/tb_cuda_alu_pipe.sv
// Self-checking bench for cuda_alu_pipe at WIDTH=4: directed cases plus a random
// stream scored against an in-order arithmetic model.
module tb_cuda_alu_pipe;
    import cuda_alu_pkg::*;

    localparam int W   = 4;
    localparam int SW  = 3;
    localparam int MOD = 1 << (W + 1);

    typedef struct {
        int out;
        int cay;
        int err;
        int acc;
        int st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t exp_q[$];
    int   m_acc = 0;
    int   m_st  = 0;
    bit   stall_prev = 1'b0;
    int   prev_out, prev_cay, prev_err;
    int   got_out[$];
    int   got_cay[$];
    int   got_err[$];
    int   got_st[$];
    bit   s_ov;

    cuda_alu_pipe_if #(.WIDTH(W), .SHW(SW)) bus ();

    cuda_alu_pipe #(.WIDTH(W), .SHW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result of one beat, applied in acceptance order.
    function automatic exp_t model(input int op, input int a, input int b, input int c,
                                   input int sh);
        exp_t e;
        int   v;
        e = '{out: 0, cay: 0, err: 0, acc: 0, st: 0};
        case (op)
            1: begin
                v = ((a & b) + c) % MOD;
                e.out = v;
                e.cay = v / (MOD / 2);
            end
            2: begin
                v = (sh > W) ? 0 : (a * (1 << sh)) % MOD;
                e.out = v;
                e.cay = v / (MOD / 2);
            end
            3: begin
                e.out = (sh >= W) ? 0 : a / (1 << sh);
                e.cay = (sh >= 1 && sh <= W) ? (a >> (sh - 1)) & 1 : 0;
            end
            4: begin
                v = m_acc + a;
                e.cay = (v >= MOD) ? 1 : 0;
                m_acc = v % MOD;
                e.out = m_acc;
            end
            5: begin
                m_acc = 0;
                m_st  = 0;
            end
            default: begin
                e.err = 1;
                m_st  = 1;
            end
        endcase
        e.acc = m_acc;
        e.st  = m_st;
        return e;
    endfunction

    task automatic step(input bit iv, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input logic [2:0] sh,
                        input bit ordy, output bit taken);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.c         = c;
        bus.sh        = sh;
        bus.out_ready = ordy;
        #1;
        s_ov = bus.out_valid;
        if (stall_prev) begin
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_out", int'(bus.out), prev_out);
            check("hold_cay", int'(bus.cay), prev_cay);
            check("hold_err", int'(bus.err), prev_err);
        end
        check("in_ready", int'(bus.in_ready), (exp_q.size() == 2 && !ordy) ? 0 : 1);
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", int'(bus.out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("res_out", int'(bus.out), e.out);
                check("res_cay", int'(bus.cay), e.cay);
                check("res_err", int'(bus.err), e.err);
                check("res_acc", int'(bus.acc), e.acc);
                check("res_sticky", int'(bus.err_sticky), e.st);
                got_out.push_back(int'(bus.out));
                got_cay.push_back(int'(bus.cay));
                got_err.push_back(int'(bus.err));
                got_st.push_back(int'(bus.err_sticky));
            end
        end
        taken = iv && bus.in_ready;
        if (taken) exp_q.push_back(model(int'(op), int'(a), int'(b), int'(c), int'(sh)));
        stall_prev = bus.out_valid && !ordy;
        prev_out   = int'(bus.out);
        prev_cay   = int'(bus.cay);
        prev_err   = int'(bus.err);
    endtask

    task automatic idle(input bit ordy);
        bit t;
        step(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 3'd0, ordy, t);
    endtask

    task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [2:0] sh);
        bit t;
        step(1'b1, op, a, b, c, sh, 1'b1, t);
        check("accept", int'(t), 1);
        idle(1'b1);
        check("lat_early", int'(s_ov), 0);
        idle(1'b1);
        check("lat", int'(s_ov), 1);
    endtask

    initial begin
        bit t;
        int sent;
        int cyc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.op = '0; bus.sh = '0;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out", int'(bus.out), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_sticky", int'(bus.err_sticky), 0);
        check("rst_acc", int'(bus.acc), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        run_one(OP_ANDADD, 4'hF, 4'hF, 4'h1, 3'd0);
        check("andadd1_out", got_out[$], 'h10);
        check("andadd1_cay", got_cay[$], 1);
        run_one(OP_ANDADD, 4'h3, 4'h5, 4'h2, 3'd0);
        check("andadd2_out", got_out[$], 'h03);
        check("andadd2_cay", got_cay[$], 0);
        run_one(OP_SHL, 4'h9, 4'h0, 4'h0, 3'd1);
        check("shl1_out", got_out[$], 'h12);
        check("shl1_cay", got_cay[$], 1);
        run_one(OP_SHR, 4'hB, 4'h0, 4'h0, 3'd1);
        check("shr1_out", got_out[$], 'h05);
        check("shr1_cay", got_cay[$], 1);
        run_one(OP_SHR, 4'hB, 4'h0, 4'h0, 3'd4);
        check("shr4_out", got_out[$], 0);
        check("shr4_cay", got_cay[$], 1);
        run_one(OP_SHL, 4'hF, 4'h0, 4'h0, 3'd5);
        check("shl5_out", got_out[$], 0);
        check("shl5_cay", got_cay[$], 0);

        got_out.delete();
        got_cay.delete();
        step(1'b1, OP_ACC, 4'h9, 4'h0, 4'h0, 3'd0, 1'b1, t);
        step(1'b1, OP_ACC, 4'h9, 4'h0, 4'h0, 3'd0, 1'b1, t);
        step(1'b1, OP_ACC, 4'hF, 4'h0, 4'h0, 3'd0, 1'b1, t);
        repeat (3) idle(1'b1);
        check("acc_count", got_out.size(), 3);
        if (got_out.size() == 3) begin
            check("acc_out0", got_out[0], 'h09);
            check("acc_out1", got_out[1], 'h12);
            check("acc_out2", got_out[2], 'h01);
            check("acc_cay2", got_cay[2], 1);
        end
        check("acc_value", int'(bus.acc), 'h01);
        run_one(OP_ACLR, 4'h0, 4'h0, 4'h0, 3'd0);
        check("aclr_out", got_out[$], 0);
        check("aclr_acc", int'(bus.acc), 0);

        run_one(3'b110, 4'h1, 4'h2, 4'h3, 3'd0);
        check("ill_err", got_err[$], 1);
        check("ill_sticky", got_st[$], 1);
        run_one(OP_ANDADD, 4'h1, 4'h1, 4'h1, 3'd0);
        check("after_ill_err", got_err[$], 0);
        check("after_ill_sticky", got_st[$], 1);
        run_one(OP_ACLR, 4'h0, 4'h0, 4'h0, 3'd0);
        check("aclr_sticky", int'(bus.err_sticky), 0);

        sent = 0;
        cyc  = 0;
        while (sent < 32 && cyc < 600) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), t);
            if (t) sent++;
            cyc++;
        end
        check("stream_sent", sent, 32);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            idle(1'b1);
            cyc++;
        end
        check("drain", exp_q.size(), 0);

        // Fill both stages under stall, then reset mid-stall.
        step(1'b1, OP_ACC, 4'h5, 4'h0, 4'h0, 3'd0, 1'b0, t);
        step(1'b1, 3'b111, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0, t);
        step(1'b1, OP_ANDADD, 4'h1, 4'h1, 4'h1, 3'd0, 1'b0, t);
        check("full_no_accept", int'(t), 0);
        check("full_out_valid", int'(s_ov), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_out", int'(bus.out), 0);
        check("mid_rst_cay", int'(bus.cay), 0);
        check("mid_rst_err", int'(bus.err), 0);
        check("mid_rst_sticky", int'(bus.err_sticky), 0);
        check("mid_rst_acc", int'(bus.acc), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_acc = 0;
        m_st  = 0;
        stall_prev = 1'b0;
        repeat (4) begin
            idle(1'b1);
            check("post_rst_quiet", int'(s_ov), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
